// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: access-size encodings, address-error cause codes
// and default datapath widths used by the EX/MEM register and fetch-side checks.
// Contents: ls_size_e, EXC_ADEL/EXC_ADES, DEF_ADDR_W/DEF_REG_W, exc_cause().
package pipe_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_REG_W  = 5;

  // Memory access size as carried in the LS_bit control field.
  typedef enum logic [1:0] {
    WORD    = 2'b00,
    HALF    = 2'b01,
    BYTE    = 2'b10,
    ILLEGAL = 2'b11
  } ls_size_e;

  // Address-error exception causes (load / store).
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic [4:0] exc_cause(input logic is_store);
    return is_store ? EXC_ADES : EXC_ADEL;
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Purely combinational alignment check for a memory access.
// Ports: size_i (ls_size_e encoding), addr_lo_i (address bits [1:0]),
//        en_i (access actually happens), misalign_o (access is misaligned).
module mem_align_check
  import pipe_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  input  logic       en_i,
  output logic       misalign_o
);

  always_comb begin
    misalign_o = 1'b0;
    if (en_i) begin
      case (size_i)
        WORD:    misalign_o = (addr_lo_i != 2'b00);
        HALF:    misalign_o = addr_lo_i[0];
        BYTE:    misalign_o = 1'b0;
        default: misalign_o = 1'b1;  // reserved size encoding is always a fault
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register feeding dm_4k: captures ALU result, store data and
// memory/write-back control each rising edge, with stall, flush and misaligned
// access detection (writes suppressed, first fault latched until exc_ack).
// Ports: clock/reset_n, stall/flush, ID_EX_* inputs, EX_MEM_* / memory control
//        outputs, exc_ack in, exc_valid/exc_pending/exc_badvaddr/exc_pc out.
module ex_mem_reg
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned REG_W  = DEF_REG_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ID_EX_valid,
  input  logic [ADDR_W-1:0] ID_EX_pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] regfile_out2,
  input  logic [1:0]        ID_EX_LS_bit,
  input  logic              ID_EX_Ext_op,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MemWrite,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemtoReg,
  input  logic [REG_W-1:0]  ID_EX_write_reg,
  input  logic              exc_ack,
  output logic              EX_MEM_valid,
  output logic [ADDR_W-1:0] EX_MEM_alu_out,
  output logic [ADDR_W-1:0] EX_MEM_regfile_out2,
  output logic [ADDR_W-1:0] EX_MEM_pc,
  output logic [1:0]        LS_bit,
  output logic              Ext_op,
  output logic              MemWrite,
  output logic              EX_MEM_MemRead,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemtoReg,
  output logic [REG_W-1:0]  EX_MEM_write_reg,
  output logic              exc_valid,
  output logic              exc_pending,
  output logic [ADDR_W-1:0] exc_badvaddr,
  output logic [ADDR_W-1:0] exc_pc
);

  logic              valid_q,     valid_d;
  logic [ADDR_W-1:0] alu_q,       alu_d;
  logic [ADDR_W-1:0] st_q,        st_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [1:0]        ls_q,        ls_d;
  logic              ext_q,       ext_d;
  logic              memwrite_q,  memwrite_d;
  logic              memread_q,   memread_d;
  logic              regwrite_q,  regwrite_d;
  logic              memtoreg_q,  memtoreg_d;
  logic [REG_W-1:0]  wreg_q,      wreg_d;
  logic              exc_valid_q, exc_valid_d;
  logic              exc_pend_q,  exc_pend_d;
  logic [ADDR_W-1:0] exc_bad_q,   exc_bad_d;
  logic [ADDR_W-1:0] exc_pc_q,    exc_pc_d;

  logic access_en;
  logic misalign;
  logic record_fault;

  assign access_en = ID_EX_valid & (ID_EX_MemRead | ID_EX_MemWrite);

  mem_align_check u_align (
    .size_i     (ID_EX_LS_bit),
    .addr_lo_i  (alu_out[1:0]),
    .en_i       (access_en),
    .misalign_o (misalign)
  );

  // A fault is latched when nothing is pending, or when the pending one is
  // being acknowledged in this very cycle (the new fault replaces it).
  assign record_fault = misalign & (~exc_pend_q | exc_ack);

  always_comb begin
    valid_d     = valid_q;
    alu_d       = alu_q;
    st_d        = st_q;
    pc_d        = pc_q;
    ls_d        = ls_q;
    ext_d       = ext_q;
    memwrite_d  = memwrite_q;
    memread_d   = memread_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    wreg_d      = wreg_q;
    exc_valid_d = 1'b0;  // pulse: only ever high for the cycle after a recorded fault
    exc_pend_d  = exc_pend_q;
    exc_bad_d   = exc_bad_q;
    exc_pc_d    = exc_pc_q;

    if (flush) begin
      // Bubble: kill every side effect; data/PC fields are don't-care and held.
      // The squashed instruction never raises an exception.
      valid_d    = 1'b0;
      memwrite_d = 1'b0;
      memread_d  = 1'b0;
      regwrite_d = 1'b0;
      ls_d       = WORD;
      if (exc_ack) begin
        exc_pend_d = 1'b0;
      end
    end else if (!stall) begin
      valid_d    = ID_EX_valid;
      alu_d      = alu_out;
      st_d       = regfile_out2;
      pc_d       = ID_EX_pc;
      ls_d       = ID_EX_LS_bit;
      ext_d      = ID_EX_Ext_op;
      memtoreg_d = ID_EX_MemtoReg;
      wreg_d     = ID_EX_write_reg;
      // Misaligned accesses keep their address/PC for debug but must not
      // touch memory or the register file.
      memwrite_d = ID_EX_MemWrite & ~misalign;
      memread_d  = ID_EX_MemRead  & ~misalign;
      regwrite_d = ID_EX_RegWrite & ~misalign;

      if (record_fault) begin
        exc_valid_d = 1'b1;
        exc_pend_d  = 1'b1;
        exc_bad_d   = alu_out;
        exc_pc_d    = ID_EX_pc;
      end else if (exc_ack) begin
        exc_pend_d  = 1'b0;
      end
    end
    // stall: everything holds, exc_valid drops via its default
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      alu_q       <= '0;
      st_q        <= '0;
      pc_q        <= '0;
      ls_q        <= '0;
      ext_q       <= 1'b0;
      memwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      wreg_q      <= '0;
      exc_valid_q <= 1'b0;
      exc_pend_q  <= 1'b0;
      exc_bad_q   <= '0;
      exc_pc_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      alu_q       <= alu_d;
      st_q        <= st_d;
      pc_q        <= pc_d;
      ls_q        <= ls_d;
      ext_q       <= ext_d;
      memwrite_q  <= memwrite_d;
      memread_q   <= memread_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      wreg_q      <= wreg_d;
      exc_valid_q <= exc_valid_d;
      exc_pend_q  <= exc_pend_d;
      exc_bad_q   <= exc_bad_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  assign EX_MEM_valid        = valid_q;
  assign EX_MEM_alu_out      = alu_q;
  assign EX_MEM_regfile_out2 = st_q;
  assign EX_MEM_pc           = pc_q;
  assign LS_bit              = ls_q;
  assign Ext_op              = ext_q;
  assign MemWrite            = memwrite_q;
  assign EX_MEM_MemRead      = memread_q;
  assign EX_MEM_RegWrite     = regwrite_q;
  assign EX_MEM_MemtoReg     = memtoreg_q;
  assign EX_MEM_write_reg    = wreg_q;
  assign exc_valid           = exc_valid_q;
  assign exc_pending         = exc_pend_q;
  assign exc_badvaddr        = exc_bad_q;
  assign exc_pc              = exc_pc_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clock = 1'b0;
  logic        reset_n, stall, flush, exc_ack;
  logic        id_valid, ext_op, mem_rd, mem_wr, reg_wr, mem2reg;
  logic [31:0] id_pc, alu, st_data;
  logic [1:0]  ls;
  logic [4:0]  wreg;

  logic        o_valid, o_ls_dummy;
  logic [31:0] o_alu, o_st, o_pc, o_bad, o_epc;
  logic [1:0]  o_ls;
  logic        o_ext, o_mw, o_mr, o_rw, o_m2r, o_ev, o_ep;
  logic [4:0]  o_wreg;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] st;
    logic [31:0] pc;
    logic [1:0]  ls;
    logic        ext;
    logic        mw;
    logic        mr;
    logic        rw;
    logic        m2r;
    logic [4:0]  wreg;
    logic        ev;
    logic        ep;
    logic [31:0] bad;
    logic [31:0] epc;
  } out_t;

  out_t act, exp_s, snap;
  int checks = 0;
  int errors = 0;

  assign o_ls_dummy = 1'b0;
  assign act = {o_valid, o_alu, o_st, o_pc, o_ls, o_ext, o_mw, o_mr, o_rw, o_m2r,
                o_wreg, o_ev, o_ep, o_bad, o_epc};

  always #5 clock = ~clock;

  ex_mem_reg #(.ADDR_W(32), .REG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .ID_EX_valid(id_valid), .ID_EX_pc(id_pc), .alu_out(alu), .regfile_out2(st_data),
    .ID_EX_LS_bit(ls), .ID_EX_Ext_op(ext_op), .ID_EX_MemRead(mem_rd),
    .ID_EX_MemWrite(mem_wr), .ID_EX_RegWrite(reg_wr), .ID_EX_MemtoReg(mem2reg),
    .ID_EX_write_reg(wreg), .exc_ack(exc_ack),
    .EX_MEM_valid(o_valid), .EX_MEM_alu_out(o_alu), .EX_MEM_regfile_out2(o_st),
    .EX_MEM_pc(o_pc), .LS_bit(o_ls), .Ext_op(o_ext), .MemWrite(o_mw),
    .EX_MEM_MemRead(o_mr), .EX_MEM_RegWrite(o_rw), .EX_MEM_MemtoReg(o_m2r),
    .EX_MEM_write_reg(o_wreg), .exc_valid(o_ev), .exc_pending(o_ep),
    .exc_badvaddr(o_bad), .exc_pc(o_epc)
  );

  // Reference model: what the register must hold after the coming edge,
  // derived directly from the behavioural rules of the block.
  function automatic out_t model_next(input out_t s);
    out_t n;
    bit   access, mis;
    n = s;
    access = id_valid && (mem_rd || mem_wr);
    mis = access && ((ls == 2'd3) ||
                     (ls == 2'd0 && (alu % 4) != 0) ||
                     (ls == 2'd1 && (alu % 2) != 0));
    if (!reset_n) begin
      n = '0;
    end else if (flush) begin
      n.valid = 0; n.mw = 0; n.mr = 0; n.rw = 0; n.ls = 2'd0; n.ev = 0;
      if (exc_ack) n.ep = 0;
    end else if (stall) begin
      n.ev = 0;
    end else begin
      n.valid = id_valid; n.alu = alu; n.st = st_data; n.pc = id_pc; n.ls = ls;
      n.ext = ext_op; n.m2r = mem2reg; n.wreg = wreg;
      n.mw = mem_wr && !mis; n.mr = mem_rd && !mis; n.rw = reg_wr && !mis;
      n.ev = 0;
      if (mis && (!s.ep || exc_ack)) begin
        n.ev = 1; n.ep = 1; n.bad = alu; n.epc = id_pc;
      end else if (exc_ack) begin
        n.ep = 0;
      end
    end
    return n;
  endfunction

  task automatic tick();
    exp_s = model_next(exp_s);
    @(posedge clock);
    #1;
  endtask

  task automatic set_ctl(input logic rst_n, input logic st, input logic fl, input logic ack);
    reset_n = rst_n; stall = st; flush = fl; exc_ack = ack;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz, input logic ext,
                           input logic rd, input logic wr, input logic rw,
                           input logic m2r, input logic [4:0] wr_reg);
    id_valid = v; id_pc = pc; alu = a; st_data = d; ls = sz; ext_op = ext;
    mem_rd = rd; mem_wr = wr; reg_wr = rw; mem2reg = m2r; wreg = wr_reg;
  endtask

  task automatic set_nop();
    set_instr(1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    set_instr(1'b1, 32'h1234, 32'h5, 32'hAAAA, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    tick();
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL reset_zero: got %h want 0", act);
    end
    checks++;
    if (act !== exp_s) begin
      errors++; $display("FAIL reset_model: got %h want %h", act, exp_s);
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_aligned_store();
    set_instr(1'b1, 32'h0040_0000, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    checks++;
    if (o_mw !== 1'b1 || o_alu !== 32'h10 || o_st !== 32'hDEAD_BEEF || o_ev !== 1'b0) begin
      errors++; $display("FAIL sw_aligned: mw=%b alu=%h st=%h ev=%b want 1/10/deadbeef/0", o_mw, o_alu, o_st, o_ev);
    end
    checks++;
    if (act !== exp_s) begin
      errors++; $display("FAIL sw_model: got %h want %h", act, exp_s);
    end
  endtask

  task automatic test_misaligned_half();
    set_instr(1'b1, 32'h0040_0020, 32'h0000_0013, 32'h55, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    checks++;
    if (o_mw !== 0 || o_rw !== 0 || o_ev !== 1 || o_ep !== 1 || o_bad !== 32'h13 || o_epc !== 32'h0040_0020) begin
      errors++; $display("FAIL sh_fault: mw=%b rw=%b ev=%b ep=%b bad=%h pc=%h want 0/0/1/1/13/00400020",
                         o_mw, o_rw, o_ev, o_ep, o_bad, o_epc);
    end
    set_nop();
    tick();
    checks++;
    if (o_ev !== 0 || o_ep !== 1 || o_bad !== 32'h13) begin
      errors++; $display("FAIL sh_pulse_one: ev=%b ep=%b bad=%h want 0/1/13", o_ev, o_ep, o_bad);
    end
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    checks++;
    if (o_ep !== 0 || act !== exp_s) begin
      errors++; $display("FAIL sh_ack: ep=%b got %h want %h", o_ep, act, exp_s);
    end
  endtask

  task automatic test_stall_flush();
    set_instr(1'b1, 32'h100, 32'h40, 32'h77, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    tick();
    snap = exp_s;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, $urandom, {$urandom} & 32'hFFFF_FFFC, $urandom, 2'b00, 1'($urandom),
                1'b0, 1'b1, 1'b1, 1'b0, 5'($urandom));
      tick();
      checks++;
      if (act !== snap || act !== exp_s) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, act, snap);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (o_valid !== 0 || o_mw !== 0 || o_mr !== 0 || o_rw !== 0 || o_ls !== 2'b00) begin
      errors++; $display("FAIL flush_bubble: v=%b mw=%b mr=%b rw=%b ls=%b want all 0", o_valid, o_mw, o_mr, o_rw, o_ls);
    end
    // misaligned instruction being flushed raises nothing
    stall = 1'b0;
    set_instr(1'b1, 32'h200, 32'h3, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    tick();
    checks++;
    if (o_ev !== 0 || o_ep !== 0 || act !== exp_s) begin
      errors++; $display("FAIL flush_no_exc: ev=%b ep=%b want 0/0", o_ev, o_ep);
    end
    flush = 1'b0;
  endtask

  task automatic test_second_fault();
    set_instr(1'b1, 32'h300, 32'h22, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    tick();
    checks++;
    if (o_ev !== 1 || o_bad !== 32'h22 || o_mr !== 0 || o_rw !== 0) begin
      errors++; $display("FAIL lw22: ev=%b bad=%h mr=%b rw=%b want 1/22/0/0", o_ev, o_bad, o_mr, o_rw);
    end
    set_instr(1'b1, 32'h304, 32'h31, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    checks++;
    if (o_ev !== 0 || o_bad !== 32'h22 || o_epc !== 32'h300 || o_ep !== 1 || o_mr !== 0) begin
      errors++; $display("FAIL lw31_ignored: ev=%b bad=%h pc=%h ep=%b mr=%b want 0/22/300/1/0", o_ev, o_bad, o_epc, o_ep, o_mr);
    end
    exc_ack = 1'b1;
    set_instr(1'b1, 32'h308, 32'h41, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
    tick();
    checks++;
    if (o_bad !== 32'h41 || o_epc !== 32'h308 || o_ep !== 1 || act !== exp_s) begin
      errors++; $display("FAIL ack_new_fault: bad=%h pc=%h ep=%b want 41/308/1", o_bad, o_epc, o_ep);
    end
    exc_ack = 1'b0;
    set_nop();
  endtask

  task automatic test_reset_mid_exc();
    set_instr(1'b1, 32'h400, 32'h2, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    stall = 1'b1;
    tick();
    checks++;
    if (o_ep !== 1) begin
      errors++; $display("FAIL pre_reset_pending: ep=%b want 1", o_ep);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL reset_mid_exc: got %h want 0", act);
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_instr(1'b1, 32'h500, 32'h8, 32'h99, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    checks++;
    if (o_mw !== 1 || o_alu !== 32'h8 || act !== exp_s) begin
      errors++; $display("FAIL first_after_reset: mw=%b alu=%h want 1/8", o_mw, o_alu);
    end
  endtask

  task automatic test_byte_loads();
    for (int a = 1; a <= 3; a++) begin
      set_instr(1'b1, 32'h600 + 32'(a), 32'(a), 32'h0, 2'b10, a[0], 1'b1, 1'b0, 1'b1, 1'b1, 5'(a));
      tick();
      checks++;
      if (o_ev !== 0 || o_mr !== 1 || o_ext !== a[0] || o_ls !== 2'b10 || o_rw !== 1) begin
        errors++; $display("FAIL byte_load[%0d]: ev=%b mr=%b ext=%b ls=%b rw=%b", a, o_ev, o_mr, o_ext, o_ls, o_rw);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_ctl(($urandom_range(0, 49) != 0), ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
      set_instr(1'($urandom_range(0, 5) != 0), $urandom, $urandom, $urandom,
                2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 5'($urandom));
      tick();
      checks++;
      if (act !== exp_s) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, act, exp_s);
      end
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_s = '0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    set_nop();
    #2;
    test_reset();
    test_aligned_store();
    test_misaligned_half();
    test_stall_flush();
    test_second_fault();
    test_reset_mid_exc();
    test_byte_loads();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
